// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS MEM-stage encodings and helpers
// Purpose: memory-op encodings, byte-enable width, default data-memory base
//          address and the store byte-enable helper.
// Ports:   none (package).
// Config:  none here; the store log is guarded by DM_STORE_LOG_EN in dm_unit.
package mips_pkg;

  localparam int MEMOP_BITS = 3;
  localparam int BE_BITS    = 4;

  localparam logic [MEMOP_BITS-1:0] MEMOP_W  = 3'd0;
  localparam logic [MEMOP_BITS-1:0] MEMOP_H  = 3'd1;
  localparam logic [MEMOP_BITS-1:0] MEMOP_HS = 3'd2;
  localparam logic [MEMOP_BITS-1:0] MEMOP_B  = 3'd3;
  localparam logic [MEMOP_BITS-1:0] MEMOP_BS = 3'd4;

  localparam logic [31:0] DM_BASE_ADDR = 32'h0000_0000;

  // Byte lanes touched by a store; reserved ops touch nothing.
  function automatic logic [BE_BITS-1:0] be_of(input logic [MEMOP_BITS-1:0] op,
                                               input logic [1:0] off);
    logic [BE_BITS-1:0] be;
    case (op)
      MEMOP_W:           be = 4'b1111;
      MEMOP_H, MEMOP_HS: be = 4'b0011 << off;
      MEMOP_B, MEMOP_BS: be = 4'b0001 << off;
      default:           be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dm_unit_if.sv
// rtl/dm_unit_if.sv - EX/MEM to data-memory request/response bundle
// Purpose: groups the MEM-stage data-memory signals.
// Ports (members):
//   memWriteM  store request          memOpM     access type
//   aluOutM    byte address           writeDataM store data
//   pcM        PC of MEM instruction  readDataM  extended load result
//   addrErrM   misaligned/out-of-range/reserved-op flag
// Modports: master = pipeline side, slave = data memory.
interface dm_unit_if;
  import mips_pkg::*;

  logic                  memWriteM;
  logic [MEMOP_BITS-1:0] memOpM;
  logic [31:0]           aluOutM;
  logic [31:0]           writeDataM;
  logic [31:0]           pcM;
  logic [31:0]           readDataM;
  logic                  addrErrM;

  modport master (
    output memWriteM, memOpM, aluOutM, writeDataM, pcM,
    input  readDataM, addrErrM
  );

  modport slave (
    input  memWriteM, memOpM, aluOutM, writeDataM, pcM,
    output readDataM, addrErrM
  );
endinterface

// File: rtl/dm_ext.sv
// rtl/dm_ext.sv - combinational load extractor/extender
// Purpose: picks the addressed half/byte out of a memory word and zero- or
//          sign-extends it according to the memory op.
// Ports:
//   word       in  32  full memory word
//   mem_op     in  3   access type (reserved ops yield 0)
//   off        in  2   byte offset within the word
//   read_data  out 32  extended result
module dm_ext
  import mips_pkg::*;
(
  input  logic [31:0]           word,
  input  logic [MEMOP_BITS-1:0] mem_op,
  input  logic [1:0]            off,
  output logic [31:0]           read_data
);

  logic [31:0] shifted;
  logic [15:0] half;
  logic [7:0]  byte_v;

  // Little-endian lanes: shifting right by 8*off brings lane off to bits [7:0].
  assign shifted = word >> {off, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half    = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    read_data = '0;
    case (mem_op)
      MEMOP_W:  read_data = word;
      MEMOP_H:  read_data = {16'h0000, half};
      MEMOP_HS: read_data = {{16{half[15]}}, half};
      MEMOP_B:  read_data = {24'h000000, byte_v};
      MEMOP_BS: read_data = {{24{byte_v[7]}}, byte_v};
      default:  read_data = '0;
    endcase
  end

endmodule

// File: rtl/dm_unit.sv
// rtl/dm_unit.sv - MEM-stage data memory responder
// Purpose: word-organised RAM with synchronous byte-enabled stores and
//          combinational width/sign-extracting loads.
// Ports:
//   clk    in  pipeline clock, all state updates on posedge
//   reset  in  synchronous active-high, clears every word
//   bus    dm_unit_if.slave (memWriteM, memOpM, aluOutM, writeDataM, pcM,
//          readDataM, addrErrM)
// Config: define DM_STORE_LOG_EN to print each committed store.
module dm_unit
  import mips_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = DM_BASE_ADDR
) (
  input  logic     clk,
  input  logic     reset,
  dm_unit_if.slave bus
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [31:0]           mem [0:WORDS-1];
  logic [31:0]           rel;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            off;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  reserved;
  logic                  addr_err;
  logic [BE_BITS-1:0]    be;
  logic [31:0]           old_word;
  logic [31:0]           wdata_rep;
  logic [31:0]           new_word;
  logic [31:0]           ext_data;
  logic                  commit;

  // Unsigned wrap is intentional: addresses below BASE_ADDR land far out of range.
  assign rel          = bus.aluOutM - BASE_ADDR;
  assign idx          = rel[DEPTH_LOG2+1:2];
  assign off          = bus.aluOutM[1:0];
  assign out_of_range = |(rel >> (DEPTH_LOG2 + 2));

  always_comb begin
    misaligned = 1'b0;
    reserved   = 1'b0;
    case (bus.memOpM)
      MEMOP_W:           misaligned = (off != 2'b00);
      MEMOP_H, MEMOP_HS: misaligned = off[0];
      MEMOP_B, MEMOP_BS: misaligned = 1'b0;
      default:           reserved   = 1'b1;
    endcase
  end

  assign addr_err = out_of_range | misaligned | reserved;
  assign be       = be_of(bus.memOpM, off);
  assign old_word = mem[idx];
  assign commit   = bus.memWriteM & ~addr_err;

  // Replicate the store data across lanes so the byte enables alone pick placement.
  always_comb begin
    wdata_rep = bus.writeDataM;
    case (bus.memOpM)
      MEMOP_H, MEMOP_HS: wdata_rep = {2{bus.writeDataM[15:0]}};
      MEMOP_B, MEMOP_BS: wdata_rep = {4{bus.writeDataM[7:0]}};
      default:           wdata_rep = bus.writeDataM;
    endcase
  end

  always_comb begin
    new_word = old_word;
    for (int k = 0; k < BE_BITS; k++) begin
      if (be[k]) new_word[8*k +: 8] = wdata_rep[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[idx] <= new_word;
    end
  end

`ifdef DM_STORE_LOG_EN
  always_ff @(posedge clk) begin
    if (!reset && commit)
      $display("@%08h: *%08h <= %08h", bus.pcM, {bus.aluOutM[31:2], 2'b00}, new_word);
  end
`endif

  // Loads see the pre-store word; there is no internal store-to-load bypass.
  dm_ext u_ext (
    .word      (old_word),
    .mem_op    (bus.memOpM),
    .off       (off),
    .read_data (ext_data)
  );

  assign bus.readDataM = addr_err ? 32'h0 : ext_data;
  assign bus.addrErrM  = addr_err;

endmodule

// File: tb/tb_dm_unit.sv
// tb/tb_dm_unit.sv - self-checking bench for dm_unit
module tb_dm_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dm_unit_if bus ();

  dm_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_rd_q[$];
  logic        exp_err_q[$];
  logic [7:0]  mb [0:63];

  task automatic check(input string nm);
    logic [31:0] erd;
    logic        eerr;
    erd  = exp_rd_q.pop_front();
    eerr = exp_err_q.pop_front();
    tests++;
    if (bus.readDataM !== erd) begin
      fails++;
      $display("FAIL %s readDataM got=%08h exp=%08h", nm, bus.readDataM, erd);
    end
    tests++;
    if (bus.addrErrM !== eerr) begin
      fails++;
      $display("FAIL %s addrErrM got=%0b exp=%0b", nm, bus.addrErrM, eerr);
    end
  endtask

  // Drive one access, sample at negedge, let the posedge commit any store.
  task automatic access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                        input string nm);
    bus.memWriteM  = we;
    bus.memOpM     = op;
    bus.aluOutM    = addr;
    bus.writeDataM = wd;
    bus.pcM        = 32'h0040_0000 + addr;
    exp_rd_q.push_back(erd);
    exp_err_q.push_back(eerr);
    @(negedge clk);
    check(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.memWriteM  = 1'b0;
    bus.memOpM     = MEMOP_W;
    bus.aluOutM    = '0;
    bus.writeDataM = '0;
    bus.pcM        = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    vecs.push_back('{1'b0, 3'd0, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_0010, 32'h8765_4321, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 32'h0000_0010, 32'h0,         32'h8765_4321, 1'b0});
    vecs.push_back('{1'b0, 3'd3, 32'h0000_0013, 32'h0,         32'h0000_0087, 1'b0});
    vecs.push_back('{1'b0, 3'd4, 32'h0000_0013, 32'h0,         32'hFFFF_FF87, 1'b0});
    vecs.push_back('{1'b0, 3'd1, 32'h0000_0012, 32'h0,         32'h0000_8765, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_0010, 32'h0,         32'h0000_4321, 1'b0});
    vecs.push_back('{1'b1, 3'd3, 32'h0000_0011, 32'h1234_56AA, 32'h0000_0043, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 32'h0000_0010, 32'h0,         32'h8765_AA21, 1'b0});
    vecs.push_back('{1'b1, 3'd1, 32'h0000_0012, 32'h5555_BEEF, 32'h0000_8765, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 32'h0000_0010, 32'h0,         32'hBEEF_AA21, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_0012, 32'h0,         32'hFFFF_BEEF, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_0020, 32'h1111_1111, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd0, 32'h0000_0020, 32'h0,         32'h1111_1111, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_0021, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_4000, 32'h5555_5555, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd5, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd7, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd0, 32'h0000_0010, 32'h0,         32'hBEEF_AA21, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_3FFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd4, 32'h0000_3FFF, 32'h0,         32'hFFFF_FFCA, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd1, 32'h0000_3FFE, 32'h0,         32'h0000_CAFE, 1'b0});

    for (int i = 0; i < vecs.size(); i++)
      access(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].err,
             $sformatf("vec%0d", i));

    // Reset coincident with a store: the store is lost, the previous store is cleared.
    access(1'b1, MEMOP_W, 32'h44, 32'h0000_9999, 32'h0, 1'b0, "pre_reset_sw");
    bus.memWriteM  = 1'b1;
    bus.memOpM     = MEMOP_W;
    bus.aluOutM    = 32'h40;
    bus.writeDataM = 32'h0000_1234;
    do_reset();
    access(1'b0, MEMOP_W, 32'h40, 32'h0, 32'h0, 1'b0, "rst_sw_lost");
    access(1'b0, MEMOP_W, 32'h44, 32'h0, 32'h0, 1'b0, "rst_prev_cleared");
    access(1'b0, MEMOP_W, 32'h10, 32'h0, 32'h0, 1'b0, "rst_old_cleared");

    // Back-to-back stores to one word, each loaded in its own store cycle.
    access(1'b1, MEMOP_W, 32'h30, 32'hA5A5_A5A5, 32'h0,         1'b0, "b2b_sw1");
    access(1'b1, MEMOP_W, 32'h30, 32'h0102_0304, 32'hA5A5_A5A5, 1'b0, "b2b_sw2_old");
    access(1'b0, MEMOP_W, 32'h30, 32'h0,         32'h0102_0304, 1'b0, "b2b_new");

    // Random accesses in words 0..15 against a byte-level model.
    do_reset();
    for (int a = 0; a < 64; a++) mb[a] = 8'h00;
    for (int n = 0; n < 80; n++) begin
      logic [2:0]  op;
      logic [5:0]  a;
      logic        we;
      logic [31:0] wd;
      logic        err;
      logic [31:0] erd;
      logic [15:0] h;
      logic [7:0]  b;
      op = 3'($urandom_range(0, 4));
      a  = 6'($urandom_range(0, 63));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      err = (op == MEMOP_W) ? (a[1:0] != 2'b00) :
            (op == MEMOP_H || op == MEMOP_HS) ? a[0] : 1'b0;
      erd = 32'h0;
      if (!err) begin
        b = mb[a];
        h = {mb[a | 6'd1], mb[a & 6'h3E]};
        case (op)
          MEMOP_W:  erd = {mb[a + 6'd3], mb[a + 6'd2], mb[a + 6'd1], mb[a]};
          MEMOP_H:  erd = {16'h0, h};
          MEMOP_HS: erd = {{16{h[15]}}, h};
          MEMOP_B:  erd = {24'h0, b};
          default:  erd = {{24{b[7]}}, b};
        endcase
      end
      access(we, op, {26'h0, a}, wd, erd, err, $sformatf("rnd%0d", n));
      if (we && !err) begin
        case (op)
          MEMOP_W: begin
            mb[a] = wd[7:0]; mb[a + 6'd1] = wd[15:8];
            mb[a + 6'd2] = wd[23:16]; mb[a + 6'd3] = wd[31:24];
          end
          MEMOP_H, MEMOP_HS: begin
            mb[a] = wd[7:0]; mb[a + 6'd1] = wd[15:8];
          end
          default: mb[a] = wd[7:0];
        endcase
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
- Data-memory responder for the MEM stage of the 5-stage MIPS pipeline.
- Consumes the EX/MEM register outputs (memWriteM, aluOutM, writeDataM, pcM) and returns readDataM toward the MEM/WB register.
- Word-organised RAM; synchronous stores with byte enables; combinational loads with width/sign extraction.

Parameters:
- DEPTH_LOG2, 12, word count is 2^DEPTH_LOG2 (4096 words = 16 KiB).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  single pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears memory contents.
- memWriteM  input  1  store request this cycle.
- memOpM  input  3  access type: 0 word, 1 half unsigned, 2 half signed, 3 byte unsigned, 4 byte signed; 5-7 reserved.
- aluOutM  input  32  byte address.
- writeDataM  input  32  store data, forwarded value of rt.
- pcM  input  32  PC of the MEM-stage instruction; used for the store log only.
- readDataM  output  32  extended load result.
- addrErrM  output  1  misaligned or out-of-range access flag.

Behaviour:
- Reset (synchronous, active-high):
  - At a posedge with reset=1, every word is cleared to 0 and any store in that cycle is ignored.
  - After reset, readDataM=0 for every in-range aligned address, and addrErrM=0 for in-range aligned addresses.
- Word index: idx = (aluOutM-BASE_ADDR)[DEPTH_LOG2+1:2]. Byte offset: off = aluOutM[1:0].
- Range check: out of range when aluOutM-BASE_ADDR >= 4*2^DEPTH_LOG2; the subtraction is unsigned and wraps.
- Alignment:
  - Word accesses need off==0.
  - Halfword accesses need off[0]==0.
  - Byte accesses are always aligned.
- addrErrM (combinational): asserted for out-of-range, misaligned, or reserved memOpM. It is evaluated every cycle, regardless of memWriteM.
- Store, at posedge with memWriteM=1, reset=0, addrErrM=0 (1-cycle latency, visible to a load in the next cycle):
  - Word: mem[idx] <= writeDataM.
  - Half: writeDataM[15:0] goes into bytes {off+1, off}; the other bytes are unchanged.
  - Byte: writeDataM[7:0] goes into byte off; the other bytes are unchanged.
  - Byte lanes are little-endian: lane k = bits [8k+7:8k].
  - A store with addrErrM=1 is dropped: no state change.
- Load (combinational, 0-cycle): read word w = mem[idx].
  - Word: w.
  - Half: w[16*off[1]+:16], zero- or sign-extended per memOpM.
  - Byte: w[8*off+:8], zero- or sign-extended per memOpM.
  - addrErrM=1 forces readDataM=0.
- Same-cycle store and load to the same word: readDataM shows the pre-store content. The post-store value appears from the next cycle. The hazard unit does not rely on DM internal bypass.
- Store-enable encoding: memOpM 0 gives be=4'b1111; 1/2 give 4'b0011<<off; 3/4 give 4'b0001<<off.
- Reset mid-sequence: a store coincident with reset is lost. Stores from the previous cycle remain cleared.

Optional Feature:
- DM_STORE_LOG_EN defined:
  - Each committed store prints "@<pcM hex8>: *<word-aligned addr hex8> <= <full new word hex8>" at that posedge.
  - Dropped and reset-cycle stores print nothing.
- Undefined: no display logic; functionally identical.

Decomposition:
- Shared package mips_pkg holds:
  - MEMOP_W, MEMOP_H, MEMOP_HS, MEMOP_B, MEMOP_BS encodings.
  - Byte-enable width.
  - Default BASE_ADDR.
- One sub-module, dm_ext: purely combinational load extractor/extender (word, memOp, off -> readData). It is reused later for the MEM/WB-side extension if extraction moves stages.

Test Plan:
- Reset, then load word at 0x0000_0100 -> readDataM=0, addrErrM=0.
- sw 0x8765_4321 to 0x10; next cycle lw 0x10 -> 0x8765_4321. lbu 0x13 -> 0x87. lb 0x13 -> 0xFFFF_FF87. lhu 0x12 -> 0x8765. lh 0x10 -> 0x4321.
- sb 0xAA to 0x11 over 0x8765_4321 -> word 0x8765_AA21. Then sh 0xBEEF to 0x12 -> word 0xBEEF_AA21.
- Misaligned cases:
  - sw to 0x22 sets addrErrM=1; a subsequent lw 0x20 returns the prior value unchanged.
  - lh at 0x21 -> addrErrM=1, readDataM=0.
- Out of range and reserved op:
  - sw to 0x0000_4000 (DEPTH_LOG2=12) -> addrErrM=1, no write.
  - memOpM=6 -> addrErrM=1.
- Reset and same-cycle behaviour:
  - sw 0x1234 to 0x40 asserted in the same cycle as reset -> lw 0x40 afterwards returns 0.
  - A same-cycle lw of a word being stored returns the old value.
